// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_pkg
// Purpose  : Shared state encoding, counter width and log2 helper for the
//            sync_fifo write-port arbiter.
// Revision : 1.0
// ============================================================================
package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int BEAT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_rr_pick
// Purpose  : Combinational rotating priority encoder; the scan starts at
//            last+1 and wraps modulo N_REQ.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    idx
);

  // Walk the scan backwards so the candidate closest to last+1 is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) begin
        found = 1'b1;
        idx   = IW'((int'(last) + k) % N_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-bounded arbiter sharing the sync_fifo write
//            port between N_REQ valid/ready producers.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 16,
  parameter  int MAX_BURST = 4,
  localparam int IW        = clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  input  logic                fifo_full,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              owner_valid;
  logic              xfer;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_valid = req_valid[owner_q];

  // Outputs are forced low while rst is high so a burst aborts in the reset cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    grant_id   = '0;
    busy       = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        xfer                = owner_valid & ~fifo_full;
        busy                = ~rst;
        grant_id            = rst ? '0 : owner_q;
        req_ready[owner_q]  = ~fifo_full & ~rst;
        fifo_wr_en          = xfer & ~rst;
        fifo_din            = (xfer & ~rst) ? req_data[owner_q*DW +: DW] : '0;
        if (!owner_valid) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (xfer) begin
          if (beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d    = ST_IDLE;
            last_d     = owner_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= IW'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire
